// File: rtl/pigasus_match_collector.sv
// Drains the Pigasus matcher's index port into a FWFT FIFO toward the core.
// Each packet closes with a terminator record carrying the match count.
module pigasus_match_collector #(
  parameter int FIFO_ADDR_WIDTH = 4,
  parameter int SETTLE_CYCLES   = 2,
  parameter int DRAIN_CYCLES    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reload,
  input  logic        flow_end,
  input  logic        match_valid,
  input  logic [15:0] match_index,
  output logic        next_index,
  output logic [15:0] m_index_data,
  output logic        m_index_last,
  output logic        m_index_valid,
  input  logic        m_index_ready,
  output logic        collector_done
);

  localparam int AW = FIFO_ADDR_WIDTH;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [7:0] DRAIN_Q = 8'(DRAIN_CYCLES);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {RUN, SETTLE, DONE} state_t;

  state_t state, state_nxt;

  logic [16:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic [15:0]   match_count;
  logic [7:0]    quiet_cnt;
  logic [7:0]    settle_cnt;
  logic          flow_seen;
  logic          armed;

  logic          full, pop, can_push, run;
  logic          capture, term, push;
  logic [16:0]   push_data;

  assign full      = (fifo_cnt == FULL_CNT);
  assign pop       = m_index_valid & m_index_ready & ~reload;
  // A same-cycle pop frees the slot for the push.
  assign can_push  = ~full | pop;
  // Async reset disarms until reload re-syncs with the wrapper.
  assign run       = (state == RUN) & armed & ~reload;
  assign capture   = run & match_valid & can_push;
  assign term      = run & ~match_valid & flow_seen
                   & (quiet_cnt == DRAIN_Q) & can_push;
  assign push      = capture | term;
  assign push_data = term ? {1'b1, match_count}
                          : {1'b0, match_index};

  assign m_index_valid = (fifo_cnt != '0);
  assign m_index_data  = m_index_valid ? mem[rd_ptr][15:0] : 16'h0;
  assign m_index_last  = m_index_valid & mem[rd_ptr][16];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN: begin
        if (capture)   state_nxt = SETTLE;
        else if (term) state_nxt = DONE;
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) state_nxt = RUN;
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = RUN;
    endcase
    if (reload) state_nxt = RUN;
  end

  always_comb begin
    next_index     = capture;
    collector_done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      match_count <= '0;
      quiet_cnt   <= '0;
      settle_cnt  <= '0;
      flow_seen   <= 1'b0;
      armed       <= 1'b0;
    end else if (reload) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      match_count <= '0;
      quiet_cnt   <= '0;
      settle_cnt  <= '0;
      flow_seen   <= 1'b0;
      armed       <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;
      if (capture && match_count != 16'hFFFF)
        match_count <= match_count + 16'h1;
      if (run) begin
        if (match_valid)              quiet_cnt <= '0;
        else if (quiet_cnt != DRAIN_Q) quiet_cnt <= quiet_cnt + 8'h1;
      end
      if (state == SETTLE && state_nxt == SETTLE)
        settle_cnt <= settle_cnt + 8'h1;
      else
        settle_cnt <= '0;
      if (flow_end && state != DONE) flow_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pigasus_match_collector.sv
// Directed bench for pigasus_match_collector with a small wrapper model
// that keeps its match stale for one cycle after each pop.
module tb_pigasus_match_collector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reload = 1'b0;
  logic        flow_end = 1'b0;
  logic        match_valid = 1'b0;
  logic [15:0] match_index = 16'h0;
  logic        next_index;
  logic [15:0] m_index_data;
  logic        m_index_last;
  logic        m_index_valid;
  logic        m_index_ready = 1'b1;
  logic        collector_done;

  int n_cmp = 0;
  int n_bad = 0;

  int widx[$];
  int wh = 0;
  bit stale = 1'b0;

  int cyc = 0;
  int ni_cnt = 0;
  int ni_consec_total = 0;
  int last_ni = 0;
  int fe_t = 0;
  bit prev_ni = 1'b0;
  int recs[$];
  int rec_t[$];
  int gaps[$];
  int ni_t[$];

  pigasus_match_collector dut (
    .clk            (clk),
    .rst            (rst),
    .reload         (reload),
    .flow_end       (flow_end),
    .match_valid    (match_valid),
    .match_index    (match_index),
    .next_index     (next_index),
    .m_index_data   (m_index_data),
    .m_index_last   (m_index_last),
    .m_index_valid  (m_index_valid),
    .m_index_ready  (m_index_ready),
    .collector_done (collector_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    match_valid = (wh < widx.size());
    match_index = match_valid ? 16'(widx[wh]) : 16'h0;
  endtask

  task automatic tick();
    bit ni_now;
    @(negedge clk);
    cyc++;
    ni_now = next_index;
    if (ni_now) begin
      if (ni_cnt > 0) gaps.push_back(cyc - last_ni);
      ni_cnt++;
      ni_t.push_back(cyc);
      last_ni = cyc;
    end
    if (ni_now && prev_ni) ni_consec_total++;
    prev_ni = ni_now;
    if (flow_end) fe_t = cyc;
    if (m_index_valid && m_index_ready) begin
      recs.push_back(int'({m_index_last, m_index_data}));
      rec_t.push_back(cyc);
    end
    @(posedge clk);
    #1;
    reload = 1'b0;
    flow_end = 1'b0;
    if (stale) begin
      wh++;
      stale = 1'b0;
    end
    if (ni_now) stale = 1'b1;
    drive();
  endtask

  task automatic start();
    wh = 0;
    stale = 1'b0;
    recs.delete();
    rec_t.delete();
    gaps.delete();
    ni_t.delete();
    ni_cnt = 0;
    reload = 1'b1;
    drive();
    tick();
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (!collector_done && k < budget) begin
      tick();
      k++;
    end
    chk(tag, collector_done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    int k;

    // reset values
    #1;
    chk("rst_next_index", next_index, 0);
    chk("rst_valid", m_index_valid, 0);
    chk("rst_data", m_index_data, 0);
    chk("rst_last", m_index_last, 0);
    chk("rst_done", collector_done, 0);
    @(negedge clk);
    rst = 1'b0;

    // single match
    m_index_ready = 1'b1;
    widx = '{32'h0123};
    start();
    flow_end = 1'b1;
    wait_done("t1_done", 60);
    repeat (3) tick();
    chk("t1_ni_cnt", ni_cnt, 1);
    chk("t1_nrec", recs.size(), 2);
    chk("t1_rec0", recs[0], 32'h0123);
    chk("t1_term", recs[1], 32'h10001);
    chk("t1_latency", rec_t[0] - ni_t[0], 1);

    // no matches
    widx.delete();
    start();
    flow_end = 1'b1;
    wait_done("t2_done", 40);
    repeat (3) tick();
    chk("t2_nrec", recs.size(), 1);
    chk("t2_term", recs[0], 32'h10000);
    d = rec_t[0] - fe_t;
    chk("t2_term_lat", (d >= 8 && d <= 9), 1);

    // burst of five
    widx = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h14};
    start();
    flow_end = 1'b1;
    wait_done("t3_done", 100);
    repeat (3) tick();
    chk("t3_ni_cnt", ni_cnt, 5);
    chk("t3_nrec", recs.size(), 6);
    for (int i = 0; i < 5; i++)
      chk($sformatf("t3_rec%0d", i), recs[i], 32'h10 + i);
    chk("t3_term", recs[5], 32'h10005);
    chk("t3_ngaps", gaps.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t3_gap%0d", i), gaps[i], 3);

    // backpressure with 20 pending
    m_index_ready = 1'b0;
    widx.delete();
    for (int i = 0; i < 20; i++) widx.push_back(32'h100 + i);
    start();
    repeat (80) tick();
    chk("t4_ni_full", ni_cnt, 16);
    chk("t4_valid", m_index_valid, 1);
    chk("t4_norec", recs.size(), 0);
    m_index_ready = 1'b1;
    flow_end = 1'b1;
    wait_done("t4_done", 300);
    repeat (25) tick();
    chk("t4_ni_cnt", ni_cnt, 20);
    chk("t4_nrec", recs.size(), 21);
    for (int i = 0; i < 20; i++)
      chk($sformatf("t4_rec%0d", i), recs[i], 32'h100 + i);
    chk("t4_term", recs[20], 32'h10014);

    // reload mid-packet
    m_index_ready = 1'b0;
    widx = '{32'h1, 32'h2, 32'h3};
    start();
    repeat (15) tick();
    chk("t5_ni_cnt", ni_cnt, 3);
    chk("t5_valid_pre", m_index_valid, 1);
    widx.delete();
    wh = 0;
    stale = 1'b0;
    reload = 1'b1;
    flow_end = 1'b1;
    drive();
    tick();
    chk("t5_valid_post", m_index_valid, 0);
    chk("t5_done_post", collector_done, 0);
    m_index_ready = 1'b1;
    repeat (30) tick();
    chk("t5_norec", recs.size(), 0);
    chk("t5_no_done", collector_done, 0);

    // async reset during SETTLE
    widx = '{32'h55, 32'h66};
    start();
    k = 0;
    while (ni_cnt == 0 && k < 10) begin
      tick();
      k++;
    end
    chk("t6_captured", ni_cnt, 1);
    chk("t6_valid_pre", m_index_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_next_index", next_index, 0);
    chk("t6_valid", m_index_valid, 0);
    chk("t6_data", m_index_data, 0);
    chk("t6_last", m_index_last, 0);
    chk("t6_done", collector_done, 0);
    #1;
    rst = 1'b0;
    widx = '{32'h77};
    start();
    repeat (10) tick();
    chk("t6_ni_cnt", ni_cnt, 1);
    chk("t6_nrec", recs.size(), 1);
    chk("t6_rec0", recs[0], 32'h77);

    chk("no_back_to_back_ni", ni_consec_total, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pigasus_match_collector.md
# pigasus_match_collector

Downstream consumer of the Pigasus string-matcher wrapper's match-index port. Drains `match_index` one entry at a time through the `next_index` handshake, honouring the wrapper's two-cycle mask-update latency. Buffers indices in an internal FIFO and presents them to the RISC-V core as a valid/ready stream. Closes each packet with a terminator record carrying the match count, once `flow_end` has been seen and the matcher has been quiet for a fixed drain window.

## Interface

Parameters:
- `FIFO_ADDR_WIDTH`, 4: output FIFO holds 2^N entries (16).
- `SETTLE_CYCLES`, 2: cycles after a `next_index` pulse before `match_valid` is trusted again. Minimum 2.
- `DRAIN_CYCLES`, 8: consecutive quiet RUN cycles required after `flow_end` before the terminator is emitted. Range 1..255.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: one clock; reset is asynchronous and active-high.
- `reload`, in, 1: packet start. Synchronous flush of FIFO, counters and state. Shared with the matcher's reload.
- `flow_end`, in, 1: one-cycle pulse. The last packet beat has been accepted by the matcher.
- `match_valid`, in, 1: wrapper has an unconsumed match.
- `match_index`, in, 16: rule index of the current match.
- `next_index`, out, 1: one-cycle pop pulse to the wrapper.
- `m_index_data`, out, 16: match index, or the match count on a terminator record.
- `m_index_last`, out, 1: 1 = terminator record.
- `m_index_valid`, out, 1: output record valid.
- `m_index_ready`, in, 1: core accepts the record.
- `collector_done`, out, 1: terminator has been pushed; the collector is idle until the next `reload`.

## Operation

- States: RUN, SETTLE, DONE. Reset and `reload` both go to RUN.
- **RUN:**
  - If `match_valid=1` and the FIFO is not full:
    - push `{last=0, match_index}`;
    - drive `next_index=1` combinationally in the same cycle;
    - increment `match_count` (16 bit, saturating at 0xFFFF);
    - clear `quiet_cnt`;
    - go to SETTLE.
  - If `match_valid=1` and the FIFO is full: no pop and no push. The wrapper holds the match. `quiet_cnt` is cleared.
  - If `match_valid=0`: `quiet_cnt` increments, saturating at `DRAIN_CYCLES`.
  - If `flow_seen=1`, `quiet_cnt==DRAIN_CYCLES`, `match_valid=0` and the FIFO is not full:
    - push `{last=1, match_count}`;
    - go to DONE.
- **SETTLE:** `settle_cnt` counts `SETTLE_CYCLES` cycles, then returns to RUN. `match_valid` is ignored here and `next_index=0`.
- **DONE:** `collector_done=1`. Matches are not popped. `flow_end` is ignored.
- **`flow_seen`:** set by `flow_end` in any state except DONE; cleared by `reload`. `flow_end` arriving while `quiet_cnt` is already saturated allows the terminator on the next RUN cycle.
- **FIFO:** first-word-fall-through. `m_index_valid` = not empty. Pop on `m_index_valid & m_index_ready`. Push and pop in the same cycle are allowed when full, because the pop frees the slot: full is evaluated before the push.
- **Reload:** takes priority over every other event, including a simultaneous `flow_end`, push or pop. Next cycle:
  - FIFO empty, `m_index_valid=0`;
  - `match_count=0`, `quiet_cnt=0`, `flow_seen=0`;
  - state RUN, `collector_done=0`.

## Timing

- Reset values:
  - `next_index=0`, `m_index_valid=0`, `m_index_data=0`, `m_index_last=0`, `collector_done=0`;
  - state RUN, all counters 0.
- Match to output: an index sampled in cycle t is on `m_index_data` with `m_index_valid=1` in cycle t+1 if the FIFO was empty.
- Pop rate: at most one `next_index` every `SETTLE_CYCLES+1` cycles (every 3 at default).
- Terminator latency: at least `DRAIN_CYCLES` RUN cycles after the last capture, and at least one cycle after `flow_end`.
- `next_index` is never asserted in consecutive cycles, nor in SETTLE or DONE.
- Async `rst` mid-packet: all outputs take their reset values immediately. `reload` is still required to re-arm the wrapper.

## Test plan

- **Single match:** `match_valid=1`, `match_index=0x0123` held until 2 cycles after `next_index`; `flow_end` pulse; `m_index_ready=1`. Required: one `next_index` pulse; output `0x0123`/last=0; then, after 8 quiet cycles, `0x0001`/last=1; `collector_done=1`.
- **No matches:** `reload`, then `flow_end`. Required: only record is `0x0000`/last=1, appearing 8–9 cycles after `flow_end`.
- **Burst of 5 matches** (wrapper model, mask updated 2 cycles after the pop): indices `0x10..0x14` emitted in order; `next_index` pulses exactly 3 cycles apart; terminator count `0x0005`.
- **Backpressure:** `m_index_ready=0`, 20 pending matches. Required: exactly 16 `next_index` pulses, no pop while full. Raising ready drains all 20 plus terminator `0x0014`; none lost or duplicated.
- **Reload mid-packet:** 3 entries buffered, `reload` coincident with `flow_end`. Required: `m_index_valid=0` next cycle; no terminator emitted; `collector_done=0`.
- **Async reset during SETTLE:** all outputs 0 within the same cycle; after release and `reload`, normal capture resumes.
